// File: rtl/if_pc_pkg.sv
// Shared types and default constants for the IF-stage PC / interrupt controller.
package if_pc_pkg;

  localparam int          XLEN_DEF       = 32;
  localparam logic [31:0] START_ADDR_DEF = 32'h0000_0000;

  // Source of the next PC, listed from highest to lowest priority
  typedef enum logic [2:0] {
    PC_SEL_RST,
    PC_SEL_RET,
    PC_SEL_IRQ,
    PC_SEL_NEXT,
    PC_SEL_HOLD
  } pc_sel_e;

endpackage

// File: rtl/if_pc_irq_ctrl_if.sv
// Bus between the IF-stage PC/interrupt controller and its neighbours
// (branch/stall logic, CSR unit, interrupt sources).
interface if_pc_irq_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic               pc_write;
  logic [XLEN-1:0]    pc_in;
  logic               csr_rst;
  logic               csr_ret;
  logic [XLEN-1:0]    csr_return_pc;
  logic [XLEN-1:0]    csr_isr_base;
  logic               csr_gie;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [NUM_IRQ-1:0] irq_in;
  logic [XLEN-1:0]    pc_out;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               irq_taken;
  logic [IDW-1:0]     irq_id;

  modport master (
    output pc_write, pc_in, csr_rst, csr_ret, csr_return_pc, csr_isr_base,
           csr_gie, irq_mask, irq_in,
    input  pc_out, irq_pending, irq_taken, irq_id
  );

  modport slave (
    input  pc_write, pc_in, csr_rst, csr_ret, csr_return_pc, csr_isr_base,
           csr_gie, irq_mask, irq_in,
    output pc_out, irq_pending, irq_taken, irq_id
  );

endinterface

// File: rtl/irq_sync_edge.sv
// Synchroniser chain for one asynchronous interrupt line followed by a
// rising-edge detector (last stage high while the history flop is still low).
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], async_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_out = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/if_pc_irq_ctrl.sv
// IF-stage program counter with a prioritised multi-channel interrupt front end.
// Define IF_PC_VECTORED_IRQ_EN for vectored ISR addresses; otherwise direct mode.
module if_pc_irq_ctrl
  import if_pc_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter int              NUM_IRQ     = 4,
  parameter int              SYNC_STAGES = 2,
  parameter logic [XLEN-1:0] START_ADDR  = XLEN'(START_ADDR_DEF)
) (
  input  logic           clk,
  input  logic           rst_n,
  if_pc_irq_ctrl_if.slave bus
);

  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [XLEN-1:0]    pc_q,      pc_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               taken_q,   taken_d;
  logic [IDW-1:0]     id_q,      id_d;

  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] irq_en;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [IDW-1:0]     winner;
  logic               take;
  logic [XLEN-1:0]    isr_addr;
  pc_sel_e            pc_sel;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (bus.irq_in[gi]),
      .edge_out (irq_edge[gi])
    );
  end

  always_comb begin
    irq_en = pending_q & bus.irq_mask;
    winner = '0;
    // Descending scan so the lowest enabled index is the one left standing
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_en[i]) winner = IDW'(i);
    end
    take = bus.csr_gie & (|irq_en);

`ifdef IF_PC_VECTORED_IRQ_EN
    isr_addr = bus.csr_isr_base + (XLEN'(winner) << 2);
`else
    isr_addr = bus.csr_isr_base;
`endif

    if (bus.csr_rst)       pc_sel = PC_SEL_RST;
    else if (bus.csr_ret)  pc_sel = PC_SEL_RET;
    else if (take)         pc_sel = PC_SEL_IRQ;
    else if (bus.pc_write) pc_sel = PC_SEL_NEXT;
    else                   pc_sel = PC_SEL_HOLD;
  end

  always_comb begin
    pc_d     = pc_q;
    clr_mask = '0;
    taken_d  = 1'b0;
    id_d     = id_q;

    case (pc_sel)
      PC_SEL_RST:  begin
        pc_d     = START_ADDR;
        clr_mask = '1;
      end
      PC_SEL_RET:  pc_d = bus.csr_return_pc;
      PC_SEL_IRQ:  begin
        pc_d    = isr_addr;
        taken_d = 1'b1;
        id_d    = winner;
        for (int i = 0; i < NUM_IRQ; i++) begin
          clr_mask[i] = (IDW'(i) == winner);
        end
      end
      PC_SEL_NEXT: pc_d = bus.pc_in;
      default:     pc_d = pc_q;
    endcase

    // A fresh edge overrides a clear on the same cycle so no request is lost
    pending_d = (pending_q & ~clr_mask) | irq_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= START_ADDR;
      pending_q <= '0;
      taken_q   <= 1'b0;
      id_q      <= '0;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      taken_q   <= taken_d;
      id_q      <= id_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.irq_pending = pending_q;
  assign bus.irq_taken   = taken_q;
  assign bus.irq_id      = id_q;

endmodule
